detect_conditioner: RTL and testbench

DETECT_CONDITIONER -- requirements
Module: detect_conditioner

---
 rtl/detect_conditioner.sv | 125 ++++++++++++
 tb/tb_detect_conditioner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/detect_conditioner.sv
// rtl/detect_conditioner.sv - debounce/hold conditioner for an asynchronous presence sensor
module detect_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  input  logic       enable,
  input  logic       clear_count,
  output logic       detect,
  output logic       detect_rise,
  output logic [7:0] event_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ACTIVE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rise_d;
  logic       sync_meta, sync_in;

  // Synchronizer runs regardless of enable so re-enable sees a fresh level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_in   <= 1'b0;
    end else begin
      sync_meta <= sensor_raw;
      sync_in   <= sync_meta;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync_in) begin
            state_d = QUALIFY;
            cnt_d   = 8'd1;
          end else begin
            cnt_d = 8'd0;
          end
        end
        QUALIFY: begin
          if (!sync_in) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ACTIVE;
            cnt_d   = 8'd0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ACTIVE: begin
          if (!sync_in) begin
            state_d = HOLD;
            cnt_d   = 8'd1;
          end
        end
        HOLD: begin
          // A retrigger from HOLD is the same detection, so no rise pulse.
          if (sync_in) begin
            state_d = ACTIVE;
            cnt_d   = 8'd0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      detect      <= 1'b0;
      detect_rise <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      detect      <= state_d[1];
      detect_rise <= rise_d;
    end
  end

  // Clear wins over a coincident increment; the count saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count <= 8'd0;
    end else if (clear_count) begin
      event_count <= 8'd0;
    end else if (rise_d && (event_count != 8'hFF)) begin
      event_count <= event_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_detect_conditioner.sv
// tb/tb_detect_conditioner.sv - scoreboard bench for detect_conditioner
module tb_detect_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       enable = 1'b1;
  logic       clear_count = 1'b0;
  logic       detect;
  logic       detect_rise;
  logic [7:0] event_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    bit         chk;
    logic [1:0] s;
    logic       d;
    logic       r;
    logic [7:0] c;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  detect_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_raw  (sensor_raw),
    .enable      (enable),
    .clear_count (clear_count),
    .detect      (detect),
    .detect_rise (detect_rise),
    .event_count (event_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [1:0] es, input logic ed,
                         input logic er, input logic [7:0] ec);
    n_checks++;
    if (state !== es || detect !== ed || detect_rise !== er || event_count !== ec) begin
      n_fail++;
      $display("FAIL %s: got state=%0d detect=%b rise=%b count=%0d, expected state=%0d detect=%b rise=%b count=%0d",
               nm, state, detect, detect_rise, event_count, es, ed, er, ec);
    end
  endtask

  // One clock of stimulus; the record describes outputs after the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic c, input bit chk,
                     input logic [1:0] s, input logic d, input logic dr,
                     input logic [7:0] ec, input string nm);
    exp_t x;
    @(negedge clk);
    sensor_raw  = r;
    enable      = e;
    clear_count = c;
    x.chk = chk; x.s = s; x.d = d; x.r = dr; x.c = ec;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  always begin
    exp_t  x;
    string nm;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (x.chk) compare(nm, x.s, x.d, x.r, x.c);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] es;
    logic       ed;

    #1 rst = 1'b1;
    #1 compare("reset_state", 2'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Rise-to-detect latency and single-cycle rise pulse.
    for (int i = 0; i < 7; i++) begin
      es = (i < 2) ? 2'd0 : (i < 5) ? 2'd1 : 2'd2;
      cyc(1'b1, 1'b1, 1'b0, 1'b1, es, (i >= 5), (i == 5), (i >= 5) ? 8'd1 : 8'd0,
          $sformatf("latency_e%0d", i));
    end

    // Low for 10 samples then high again: retrigger from HOLD.
    for (int i = 0; i < 14; i++) begin
      es = (i < 2) ? 2'd2 : (i < 12) ? 2'd3 : 2'd2;
      cyc((i >= 10), 1'b1, 1'b0, 1'b1, es, 1'b1, 1'b0, 8'd1, $sformatf("retrigger_e%0d", i));
    end

    // Held low: release after exactly 16 low samples.
    for (int i = 0; i < 19; i++) begin
      es = (i < 2) ? 2'd2 : (i < 17) ? 2'd3 : 2'd0;
      cyc(1'b0, 1'b1, 1'b0, 1'b1, es, (i < 17), 1'b0, 8'd1, $sformatf("release_e%0d", i));
    end

    // Glitch of 3 high cycles: QUALIFY then back to IDLE.
    for (int i = 0; i < 8; i++) begin
      es = (i >= 2 && i <= 4) ? 2'd1 : 2'd0;
      cyc((i < 3), 1'b1, 1'b0, 1'b1, es, 1'b0, 1'b0, 8'd1, $sformatf("glitch_e%0d", i));
    end

    // Second detection, then enable=0 while ACTIVE.
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b1, 1'b0, (i >= 5), 2'd2, 1'b1, (i == 5), 8'd2, $sformatf("second_e%0d", i));
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'd2, "disable_active");

    // Enable toggling with raw held high drives the count up to saturation.
    for (int k = 0; k < 253; k++) begin
      for (int i = 0; i < 5; i++)
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, "pump");
      cyc(1'b1, 1'b0, 1'b0, (k == 252), 2'd0, 1'b0, 1'b0, 8'd255, "count_reaches_255");
    end
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 1'b0, (i >= 3), 2'd2, 1'b1, (i == 3), 8'd255, $sformatf("saturate_e%0d", i));

    // Into HOLD, then asynchronous reset mid-cycle.
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, 1'b0, (i == 5), 2'd3, 1'b1, 1'b0, 8'd255, "hold_before_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 compare("async_reset_mid_hold", 2'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // First detection after reset follows normal latency.
    for (int i = 0; i < 7; i++) begin
      es = (i < 2) ? 2'd0 : (i < 5) ? 2'd1 : 2'd2;
      cyc(1'b1, 1'b1, 1'b0, 1'b1, es, (i >= 5), (i == 5), (i >= 5) ? 8'd1 : 8'd0,
          $sformatf("post_reset_e%0d", i));
    end

    // clear_count coincident with the qualifying edge wins over the increment.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'd1, "disable_keeps_count");
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, (i == 3), (i >= 3), 2'd2, 1'b1, (i == 3), 8'd0, $sformatf("clear_vs_rise_e%0d", i));

    @(posedge clk);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
